exec_phase_seq: RTL and testbench

//  Sequencer for the execution phases of the P-D/P-M control path. Holds the one-hot

---
 rtl/exec_phase_seq.sv | 218 +++++++++++++++++++++
 tb/tb_exec_phase_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_phase_seq.sv
// rtl/exec_phase_seq.sv - execution phase sequencer for the P-D/P-M control path
//
// Purpose:
//   Steps the one-hot execution state (PP, W$, WE, WX, WA, WZ, WP, WR, WM, WW).
//   Each execution state runs sub-phase S1 (strob1) and then S2 (strob2).
//   The decoder's enter-state requests are sampled on the S2 cycle.
//   WR/WW perform a memory handshake and WM performs an IO handshake;
//   these states hold S1 until the answer arrives or the timeout fires.
//   FP hands control to the FPU, and KC marks the end of the instruction cycle.
//
// Optional feature:
//   PHASE_STEP_EN - adds step_mode/step. With step_mode=1, every S2 is held
//   until a step pulse arrives, and the decision is taken on that cycle.
//
// Ports:
//   clk_sys, clr          clock; synchronous active-high reset
//   start                 leave IDLE and begin at PP/S1
//   ewz..ewx              enter-state requests, sampled in S2 only
//   ekc_1, ekc_2          cycle-end requests (highest priority in S2)
//   efp                   enter FP state
//   fp_done               FPU finished
//   mem_ok, io_ok         memory / IO answers
//   pp..ww                one-hot current execution state
//   strob1, strob2        sub-phase strobes
//   mem_req, io_req       handshake requests
//   fp_req                FPU busy request
//   kc                    one-cycle cycle-complete pulse
//   alarm                 one-cycle timeout pulse
//   seq_err               one-cycle bad-decode pulse
//   busy                  not IDLE
//
// Timeout behaviour:
//   On the MEM_TIMEOUT-th S1 cycle without an answer, alarm pulses and the
//   request is withdrawn on that same cycle. KC follows on the next cycle.
module exec_phase_seq #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TMR_W       = 7
) (
  input  logic clk_sys,
  input  logic clr,
  input  logic start,
  input  logic ewz,
  input  logic ew$,
  input  logic ewe,
  input  logic ewa,
  input  logic ewp,
  input  logic ewr,
  input  logic ewm,
  input  logic eww,
  input  logic ewx,
  input  logic ekc_1,
  input  logic ekc_2,
  input  logic efp,
  input  logic fp_done,
  input  logic mem_ok,
  input  logic io_ok,
`ifdef PHASE_STEP_EN
  input  logic step_mode,
  input  logic step,
`endif
  output logic pp,
  output logic w$,
  output logic we,
  output logic wx,
  output logic wa,
  output logic wz,
  output logic wp,
  output logic wr,
  output logic wm,
  output logic ww,
  output logic strob1,
  output logic strob2,
  output logic mem_req,
  output logic io_req,
  output logic fp_req,
  output logic kc,
  output logic alarm,
  output logic seq_err,
  output logic busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_PP, ST_WD, ST_WE, ST_WX, ST_WA, ST_WZ,
    ST_WP, ST_WR, ST_WM, ST_WW, ST_FP, ST_KC
  } state_t;

  state_t             state, state_n;
  logic               s2, s2_n;
  logic [TMR_W-1:0]   tmr, tmr_n;

  logic [8:0] ew_vec;
  logic       ew_one;
  state_t     ew_tgt;
  logic       hs_state;
  logic       ok_in;
  logic       tmr_hit;
  logic       s2_hold;

  assign ew_vec  = {ewz, ew$, ewe, ewa, ewp, ewr, ewm, eww, ewx};
  // Exactly one request: non-zero and clearing the lowest set bit leaves zero.
  assign ew_one  = (ew_vec != 9'd0) && ((ew_vec & (ew_vec - 9'd1)) == 9'd0);
  assign hs_state = (state == ST_WR) || (state == ST_WW) || (state == ST_WM);
  // WM listens to io_ok only; WR/WW listen to mem_ok only.
  assign ok_in   = (state == ST_WM) ? io_ok : mem_ok;
  assign tmr_hit = (tmr == TMR_W'(MEM_TIMEOUT - 1));

`ifdef PHASE_STEP_EN
  assign s2_hold = step_mode && !step;
`else
  assign s2_hold = 1'b0;
`endif

  // The target is only used when ew_one is set, so priority among bits is moot.
  always_comb begin
    ew_tgt = ST_KC;
    if (ewz) ew_tgt = ST_WZ;
    if (ew$) ew_tgt = ST_WD;
    if (ewe) ew_tgt = ST_WE;
    if (ewa) ew_tgt = ST_WA;
    if (ewp) ew_tgt = ST_WP;
    if (ewr) ew_tgt = ST_WR;
    if (ewm) ew_tgt = ST_WM;
    if (eww) ew_tgt = ST_WW;
    if (ewx) ew_tgt = ST_WX;
  end

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      state <= ST_IDLE;
      s2    <= 1'b0;
      tmr   <= '0;
    end else begin
      state <= state_n;
      s2    <= s2_n;
      tmr   <= tmr_n;
    end
  end

  always_comb begin
    state_n = state;
    s2_n    = s2;
    tmr_n   = '0;
    strob1  = 1'b0;
    strob2  = 1'b0;
    mem_req = 1'b0;
    io_req  = 1'b0;
    fp_req  = 1'b0;
    kc      = 1'b0;
    alarm   = 1'b0;
    seq_err = 1'b0;

    case (state)
      ST_IDLE: begin
        s2_n = 1'b0;
        if (start) state_n = ST_PP;
      end

      ST_FP: begin
        fp_req = 1'b1;
        if (fp_done) state_n = ST_KC;
      end

      ST_KC: begin
        kc      = 1'b1;
        state_n = ST_IDLE;
      end

      default: begin
        if (!s2) begin
          strob1 = 1'b1;
          if (!hs_state) begin
            s2_n = 1'b1;
          end else if (ok_in) begin
            // The answer wins over a coincident timeout.
            mem_req = (state != ST_WM);
            io_req  = (state == ST_WM);
            s2_n    = 1'b1;
          end else if (tmr_hit) begin
            alarm   = 1'b1;
            state_n = ST_KC;
          end else begin
            mem_req = (state != ST_WM);
            io_req  = (state == ST_WM);
            tmr_n   = tmr + 1'b1;
          end
        end else begin
          strob2 = 1'b1;
          if (!s2_hold) begin
            s2_n = 1'b0;
            if (ekc_1 || ekc_2) begin
              state_n = ST_KC;
            end else if (efp) begin
              state_n = ST_FP;
            end else if (ew_one) begin
              state_n = ew_tgt;
            end else begin
              seq_err = 1'b1;
              state_n = ST_KC;
            end
          end
        end
      end
    endcase
  end

  assign pp   = (state == ST_PP);
  assign w$   = (state == ST_WD);
  assign we   = (state == ST_WE);
  assign wx   = (state == ST_WX);
  assign wa   = (state == ST_WA);
  assign wz   = (state == ST_WZ);
  assign wp   = (state == ST_WP);
  assign wr   = (state == ST_WR);
  assign wm   = (state == ST_WM);
  assign ww   = (state == ST_WW);
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_exec_phase_seq.sv
// tb/tb_exec_phase_seq.sv - self-checking bench for exec_phase_seq
module tb_exec_phase_seq;

  logic       clk_sys = 1'b0;
  logic       clr, start, efp, fp_done, mem_ok, io_ok;
  logic [8:0] ew;
  logic [1:0] ekc;
  logic [9:0] st_o;
  logic       strob1, strob2, mem_req, io_req, fp_req, kc, alarm, seq_err, busy;
`ifdef PHASE_STEP_EN
  logic       step_mode, step;
`endif

  always #5 clk_sys = ~clk_sys;

  exec_phase_seq dut (
    .clk_sys(clk_sys), .clr(clr), .start(start),
    .ewz(ew[8]), .ew$(ew[7]), .ewe(ew[6]), .ewa(ew[5]), .ewp(ew[4]),
    .ewr(ew[3]), .ewm(ew[2]), .eww(ew[1]), .ewx(ew[0]),
    .ekc_1(ekc[1]), .ekc_2(ekc[0]), .efp(efp), .fp_done(fp_done),
    .mem_ok(mem_ok), .io_ok(io_ok),
`ifdef PHASE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .pp(st_o[9]), .w$(st_o[8]), .we(st_o[7]), .wx(st_o[6]), .wa(st_o[5]),
    .wz(st_o[4]), .wp(st_o[3]), .wr(st_o[2]), .wm(st_o[1]), .ww(st_o[0]),
    .strob1(strob1), .strob2(strob2), .mem_req(mem_req), .io_req(io_req),
    .fp_req(fp_req), .kc(kc), .alarm(alarm), .seq_err(seq_err), .busy(busy)
  );

  localparam logic [9:0] T_NO = 10'b0000000000;
  localparam logic [9:0] T_PP = 10'b1000000000;
  localparam logic [9:0] T_WE = 10'b0010000000;
  localparam logic [9:0] T_WX = 10'b0001000000;
  localparam logic [9:0] T_WA = 10'b0000100000;
  localparam logic [9:0] T_WR = 10'b0000000100;
  localparam logic [9:0] T_WM = 10'b0000000010;
  localparam logic [9:0] T_WW = 10'b0000000001;

  localparam logic [8:0] F_S1 = 9'b100000000;
  localparam logic [8:0] F_S2 = 9'b010000000;
  localparam logic [8:0] F_MR = 9'b001000000;
  localparam logic [8:0] F_IR = 9'b000100000;
  localparam logic [8:0] F_FR = 9'b000010000;
  localparam logic [8:0] F_KC = 9'b000001000;
  localparam logic [8:0] F_AL = 9'b000000100;
  localparam logic [8:0] F_SE = 9'b000000010;
  localparam logic [8:0] F_BZ = 9'b000000001;

  localparam logic [8:0] E_NO = 9'b000000000;
  localparam logic [8:0] E_E  = 9'b001000000;
  localparam logic [8:0] E_A  = 9'b000100000;
  localparam logic [8:0] E_R  = 9'b000001000;
  localparam logic [8:0] E_M  = 9'b000000100;
  localparam logic [8:0] E_W  = 9'b000000010;
  localparam logic [8:0] E_X  = 9'b000000001;

  typedef struct {
    logic       clr;
    logic       start;
    logic [8:0] ew;
    logic [1:0] ekc;
    logic       efp;
    logic       fpd;
    logic       mok;
    logic       iok;
    logic [18:0] exp;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [18:0] ex(input logic [9:0] st, input logic [8:0] fl);
    return {st, fl};
  endfunction

  task automatic add(input logic c, input logic s, input logic [8:0] e,
                     input logic [1:0] k, input logic f, input logic fd,
                     input logic mo, input logic io, input logic [18:0] x);
    vec_t v;
    v.clr = c; v.start = s; v.ew = e; v.ekc = k; v.efp = f;
    v.fpd = fd; v.mok = mo; v.iok = io; v.exp = x;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [18:0] act();
    return {st_o, strob1, strob2, mem_req, io_req, fp_req, kc, alarm, seq_err, busy};
  endfunction

  task automatic idle_inputs();
    clr = 1'b0; start = 1'b0; ew = '0; ekc = '0; efp = 1'b0;
    fp_done = 1'b0; mem_ok = 1'b0; io_ok = 1'b0;
  endtask

  initial begin
    int n;
    int mr_cycles;
    bit got_alarm;

    idle_inputs();
`ifdef PHASE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    clr = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    clr = 1'b0;

    // Reset state, then basic PP -> WA -> KC, start during KC ignored.
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_A ,2'b00,0,0,0,0, ex(T_PP, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_WA, F_S1|F_BZ));
    add(0,0,E_NO,2'b01,0,0,0,0, ex(T_WA, F_S2|F_BZ));
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    // WR with mem_ok on the 3rd S1 cycle (S1 enter inputs ignored), WX, FP.
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_R ,2'b00,0,0,0,0, ex(T_PP, F_S2|F_BZ));
    add(0,0,E_A ,2'b11,1,0,0,0, ex(T_WR, F_S1|F_MR|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,1, ex(T_WR, F_S1|F_MR|F_BZ));
    add(0,0,E_NO,2'b00,0,0,1,0, ex(T_WR, F_S1|F_MR|F_BZ));
    add(0,0,E_X ,2'b00,0,0,0,0, ex(T_WR, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_WX, F_S1|F_BZ));
    add(0,0,E_NO,2'b00,1,0,0,0, ex(T_WX, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_FR|F_BZ));
    add(0,0,E_NO,2'b00,0,1,0,0, ex(T_NO, F_FR|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    // Two ew* at once -> seq_err; none at all -> seq_err.
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_A|E_E,2'b00,0,0,0,0, ex(T_PP, F_S2|F_SE|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S2|F_SE|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    // ekc_1 beats efp: no FP state, straight to KC.
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_W ,2'b10,1,0,0,0, ex(T_PP, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    // Same-state re-entry, WM ignores mem_ok, io_ok, FP with fp_done on entry.
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_E ,2'b00,0,0,0,0, ex(T_PP, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_WE, F_S1|F_BZ));
    add(0,0,E_E ,2'b00,0,0,0,0, ex(T_WE, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_WE, F_S1|F_BZ));
    add(0,0,E_M ,2'b00,0,0,0,0, ex(T_WE, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,1,0, ex(T_WM, F_S1|F_IR|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,1, ex(T_WM, F_S1|F_IR|F_BZ));
    add(0,0,E_NO,2'b00,1,0,0,0, ex(T_WM, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,1,0,0, ex(T_NO, F_FR|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    // WR: mem_ok exactly on the timeout cycle -> ok wins, no alarm.
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_R ,2'b00,0,0,0,0, ex(T_PP, F_S2|F_BZ));
    for (int i = 0; i < 63; i++)
      add(0,0,E_NO,2'b00,0,0,0,0, ex(T_WR, F_S1|F_MR|F_BZ));
    add(0,0,E_NO,2'b00,0,0,1,0, ex(T_WR, F_S1|F_MR|F_BZ));
    add(0,0,E_NO,2'b01,0,0,0,0, ex(T_WR, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    // clr mid-WR while mem_req is high; start accepted right after.
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_R ,2'b00,0,0,0,0, ex(T_PP, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_WR, F_S1|F_MR|F_BZ));
    add(1,0,E_NO,2'b00,0,0,0,0, ex(T_WR, F_S1|F_MR|F_BZ));
    add(0,1,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_PP, F_S1|F_BZ));
    add(0,0,E_NO,2'b10,0,0,0,0, ex(T_PP, F_S2|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, F_KC|F_BZ));
    add(0,0,E_NO,2'b00,0,0,0,0, ex(T_NO, 9'd0));

    for (int i = 0; i < vq.size(); i++) begin
      clr = vq[i].clr; start = vq[i].start; ew = vq[i].ew; ekc = vq[i].ekc;
      efp = vq[i].efp; fp_done = vq[i].fpd; mem_ok = vq[i].mok; io_ok = vq[i].iok;
      #1;
      check("vec", i, 32'(act()), 32'(vq[i].exp));
      tick();
    end
    idle_inputs();

    // WW with no answer: alarm on the 64th S1 cycle, request low with it, KC next.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ew = E_W; tick(); ew = E_NO;
    n = 0; mr_cycles = 0; got_alarm = 1'b0;
    while (!got_alarm && n < 100) begin
      #1;
      n++;
      if (alarm) begin
        got_alarm = 1'b1;
        check("to_mreq", n, 32'(mem_req), 32'd0);
        check("to_state", n, 32'(st_o), 32'(T_WW));
      end else begin
        if (mem_req && strob1 && st_o == T_WW) mr_cycles++;
        tick();
      end
    end
    check("to_seen", 0, 32'(got_alarm), 32'd1);
    check("to_cycles", 0, 32'(n), 32'd64);
    check("to_mreq_len", 0, 32'(mr_cycles), 32'd63);
    tick();
    check("to_kc", 0, 32'({kc, alarm, mem_req, busy}), 32'b1001);
    tick();
    check("to_idle", 0, 32'(busy), 32'd0);

`ifdef PHASE_STEP_EN
    // Step mode: PP/S2 held 10 cycles, step on the 10th, then WA/S1.
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("step_hold", i, 32'({st_o, strob1, strob2}), 32'({T_PP, 2'b01}));
      tick();
    end
    ew = E_A; step = 1'b1; #1;
    check("step_last", 0, 32'({st_o, strob1, strob2}), 32'({T_PP, 2'b01}));
    tick(); ew = E_NO; step = 1'b0;
    check("step_next", 0, 32'({st_o, strob1, strob2}), 32'({T_WA, 2'b10}));
    step_mode = 1'b0;
    tick();
    ekc = 2'b01; tick(); ekc = 2'b00;
    check("step_kc", 0, 32'(kc), 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
